// File: rtl/alu_iter_pkg.sv
// Shared definitions for the iterative ALU: operation codes, FSM states, default sizes.
package alu_iter_pkg;

   localparam int unsigned WIDTH_DEF      = 32;
   localparam int unsigned MUL_CYCLES_DEF = 32;
   localparam int unsigned ALU_CTRL_W     = 3;

   // ALUCtrl encodings; 3'b101 and 3'b110 are undefined and behave like NOP
   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b011,
      ALU_MUL = 3'b100,
      ALU_NOP = 3'b111
   } alu_ctrl_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

   // True when the raw control code selects the multi-cycle multiply
   function automatic logic is_mul(input logic [ALU_CTRL_W-1:0] ctrl);
      return ctrl == ALU_MUL;
   endfunction

endpackage

// File: rtl/alu_iter_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
module mul_seq
   import alu_iter_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned CYCLES = MUL_CYCLES_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_c,
   output logic [WIDTH-1:0] result_c
);

   localparam int unsigned      CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_sum_c;

   // Next-state for the iteration; done/result reflect the add performed on the final edge
   always_comb begin
      active_d  = active_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
      done_c    = active_q && (cnt_q == CNT_LAST);
      result_c  = acc_sum_c;

      if (active_q) begin
         acc_d    = acc_sum_c;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (done_c) begin
            active_d = 1'b0;
         end
      end else if (start_i) begin
         active_d = 1'b1;
         cnt_d    = '0;
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end
   end

   // Iteration registers; reset aborts any multiply in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/alu_iter.sv
// ALU with single-cycle logic/arith ops and a multi-cycle iterative multiply that stalls upstream.
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
   input  logic [WIDTH-1:0]      data1_i,
   input  logic [WIDTH-1:0]      data2_i,
   output logic [WIDTH-1:0]      data_o,
   output logic                  zero_o,
   output logic                  valid_o,
   output logic                  stall_o
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;

   logic [WIDTH-1:0] alu_res_c;
   logic             mul_start_c;
   logic             mul_done_c;
   logic [WIDTH-1:0] mul_res_c;

   mul_seq #(
      .WIDTH  (WIDTH),
      .CYCLES (MUL_CYCLES)
   ) u_mul_seq (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .start_i  (mul_start_c),
      .a_i      (data1_i),
      .b_i      (data2_i),
      .done_c   (mul_done_c),
      .result_c (mul_res_c)
   );

   // Single-cycle result; NOP and undefined codes produce zero
   always_comb begin
      alu_res_c = '0;
      case (ALUCtrl_i)
         ALU_AND: alu_res_c = data1_i & data2_i;
         ALU_OR:  alu_res_c = data1_i | data2_i;
         ALU_ADD: alu_res_c = data1_i + data2_i;
         ALU_SUB: alu_res_c = data1_i - data2_i;
         default: alu_res_c = '0;
      endcase
   end

   // Control FSM and output register next-state; inputs are ignored while multiplying
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      zero_d      = zero_q;
      valid_d     = 1'b0;
      mul_start_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (is_mul(ALUCtrl_i)) begin
                  mul_start_c = 1'b1;
                  state_d     = ST_MUL;
               end else begin
                  data_d  = alu_res_c;
                  zero_d  = (alu_res_c == '0);
                  valid_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (mul_done_c) begin
               data_d  = mul_res_c;
               zero_d  = (mul_res_c == '0);
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign zero_o  = zero_q;
   assign valid_o = valid_q;
   assign stall_o = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_iter.sv
// Directed, table-driven bench for alu_iter with hand-written multiply and reset sequences.
module tb_alu_iter;

   localparam int unsigned W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         valid_i;
   logic [2:0]   ALUCtrl_i;
   logic [W-1:0] data1_i;
   logic [W-1:0] data2_i;
   logic [W-1:0] data_o;
   logic         zero_o;
   logic         valid_o;
   logic         stall_o;

   int n_tests = 0;
   int n_fail  = 0;

   alu_iter #(.WIDTH(32), .MUL_CYCLES(32)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .data_o    (data_o),
      .zero_o    (zero_o),
      .valid_o   (valid_o),
      .stall_o   (stall_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_data;
      logic         exp_zero;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      valid_i   = v;
      ALUCtrl_i = op;
      data1_i   = a;
      data2_i   = b;
   endtask

   // Present a multiply, optionally hold a different op on the bus during the stall,
   // and check stall length, held output, and the single completion pulse.
   task automatic run_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input logic [W-1:0] prev_data,
                          input logic keep_valid);
      int stall_cnt;
      int bad;
      drive(1'b1, 3'b100, a, b);
      step();
      check({name, " capture valid_o"}, W'(valid_o), W'(0));
      if (keep_valid) drive(1'b1, 3'b010, 32'd1, 32'd1);
      else            drive(1'b0, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678);
      stall_cnt = 0;
      bad       = 0;
      while (stall_o && stall_cnt < 40) begin
         stall_cnt++;
         if (valid_o !== 1'b0 || data_o !== prev_data) bad++;
         step();
      end
      check({name, " stall cycles"}, W'(stall_cnt), W'(32));
      check({name, " output disturbed during stall"}, W'(bad), W'(0));
      check({name, " done valid_o"}, W'(valid_o), W'(1));
      check({name, " result"}, data_o, exp);
      check({name, " zero_o"}, W'(zero_o), W'(exp == '0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{3'b010, 32'd5,         32'd7,         32'd12,        1'b0};
      vecs[1]  = '{3'b011, 32'd3,         32'd3,         32'd0,         1'b1};
      vecs[2]  = '{3'b011, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
      vecs[3]  = '{3'b000, 32'hF0,        32'h3C,        32'h30,        1'b0};
      vecs[4]  = '{3'b001, 32'hF0,        32'h0F,        32'hFF,        1'b0};
      vecs[5]  = '{3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
      vecs[6]  = '{3'b010, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0};
      vecs[7]  = '{3'b101, 32'd5,         32'd7,         32'd0,         1'b1};
      vecs[8]  = '{3'b110, 32'hAAAA_5555, 32'h1234_5678, 32'd0,         1'b1};
      vecs[9]  = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b1};
      vecs[10] = '{3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0};
      vecs[11] = '{3'b011, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0};

      rst_i = 1'b1;
      drive(1'b0, 3'b000, '0, '0);
      #2;
      check("reset data_o", data_o, 32'd0);
      check("reset zero_o", W'(zero_o), W'(1));
      check("reset valid_o", W'(valid_o), W'(0));
      check("reset stall_o", W'(stall_o), W'(0));
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single-cycle vectors, each followed by an idle cycle that must hold the result
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
         step();
         check($sformatf("vec%0d data_o", i), data_o, vecs[i].exp_data);
         check($sformatf("vec%0d zero_o", i), W'(zero_o), W'(vecs[i].exp_zero));
         check($sformatf("vec%0d valid_o", i), W'(valid_o), W'(1));
         check($sformatf("vec%0d stall_o", i), W'(stall_o), W'(0));
         drive(1'b0, vecs[i].op, 32'h5555_AAAA, 32'h0000_0003);
         step();
         check($sformatf("vec%0d idle valid_o", i), W'(valid_o), W'(0));
         check($sformatf("vec%0d idle data_o", i), data_o, vecs[i].exp_data);
      end

      // Multiply with no traffic during the stall, then pulse must drop
      run_mul("mul_0x10001", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001,
              32'h7FFF_FFFF, 1'b0);
      step();
      check("mul_0x10001 pulse drop", W'(valid_o), W'(0));
      check("mul_0x10001 hold", data_o, 32'h0002_0001);

      run_mul("mul_123x456", 32'd123, 32'd456, 32'd56088, 32'h0002_0001, 1'b0);
      step();

      run_mul("mul_zero", 32'h1234_5678, 32'd0, 32'd0, 32'd56088, 1'b0);
      step();

      // ADD held on the bus during the stall is accepted on the first stall-free edge
      run_mul("mul_ffff_x2", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd0, 1'b1);
      step();
      check("post-mul add valid_o", W'(valid_o), W'(1));
      check("post-mul add data_o", data_o, 32'd2);
      check("post-mul add stall_o", W'(stall_o), W'(0));
      drive(1'b0, 3'b000, '0, '0);
      step();
      check("post-mul add pulse drop", W'(valid_o), W'(0));

      // Reset ten cycles into a multiply aborts it asynchronously
      drive(1'b1, 3'b100, 32'd3, 32'd5);
      step();
      drive(1'b0, 3'b000, '0, '0);
      for (int i = 0; i < 10; i++) step();
      check("pre-reset stall_o", W'(stall_o), W'(1));
      rst_i = 1'b1;
      #1;
      check("async reset data_o", data_o, 32'd0);
      check("async reset zero_o", W'(zero_o), W'(1));
      check("async reset valid_o", W'(valid_o), W'(0));
      check("async reset stall_o", W'(stall_o), W'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      begin
         int spurious;
         spurious = 0;
         for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o !== 1'b0 || stall_o !== 1'b0) spurious++;
         end
         check("aborted mul no activity", W'(spurious), W'(0));
      end
      drive(1'b1, 3'b000, 32'hF0, 32'h3C);
      step();
      check("after reset and data_o", data_o, 32'h30);
      check("after reset and valid_o", W'(valid_o), W'(1));
      drive(1'b0, 3'b000, '0, '0);
      step();

      // First edge after reset release accepts an op
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(1'b1, 3'b001, 32'h100, 32'h001);
      step();
      check("first edge after reset data_o", data_o, 32'h101);
      check("first edge after reset valid_o", W'(valid_o), W'(1));
      drive(1'b0, 3'b000, '0, '0);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
